// File: rtl/mat_mult_pkg.sv
// Types and constants shared by the 2x2 matrix-multiplier core and its host driver.
package mat_mult_pkg;

    localparam int DATA_W = 16;
    localparam int PROD_W = 32;
    localparam int MM_LAT = 3;

    typedef struct packed {
        logic signed [DATA_W-1:0] a;
        logic signed [DATA_W-1:0] b;
        logic signed [DATA_W-1:0] c;
        logic signed [DATA_W-1:0] d;
        logic signed [DATA_W-1:0] e;
        logic signed [DATA_W-1:0] f;
        logic signed [DATA_W-1:0] g;
        logic signed [DATA_W-1:0] h;
    } mm_operands_t;

    typedef struct packed {
        logic signed [PROD_W-1:0] w;
        logic signed [PROD_W-1:0] x;
        logic signed [PROD_W-1:0] z;
        logic signed [PROD_W-1:0] y;
    } mm_result_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } host_state_t;

endpackage

// File: rtl/mat_mult_result_fifo.sv
// Result FIFO for the matrix-multiplier host: registered head entry, occupancy count,
// storage cleared on reset so the head reads zero until the first push.
module mat_mult_result_fifo
    import mat_mult_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_push,
    input  mm_result_t                     i_data,
    input  logic                           i_pop,
    output mm_result_t                     o_head,
    output logic                           o_valid,
    output logic [$clog2(DEPTH+1)-1:0]     o_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    mm_result_t        r_mem [DEPTH];
    mm_result_t        r_head;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_do_push;
    logic              w_do_pop;
    logic [AW-1:0]     w_rd_nxt;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && (r_count != CNT_W'(DEPTH));
    assign w_rd_nxt  = r_rd_ptr + AW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_nxt;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Head is the next stored entry after a pop, or the incoming word when the
    // FIFO is (or is about to become) empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
        end else if (w_do_pop && (r_count > CNT_W'(1))) begin
            r_head <= r_mem[w_rd_nxt];
        end else if (w_do_push && ((r_count == '0) || (w_do_pop && (r_count == CNT_W'(1))))) begin
            r_head <= i_data;
        end
    end

    assign o_head  = r_head;
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/mat_mult_2x2_host.sv
// Initiator for the 2x2 pipelined matrix-multiplier core: credit-based issue of
// operand sets, result capture into a FIFO, and sticky fault detection.
module mat_mult_2x2_host
    import mat_mult_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  in_a,
    input  logic signed [DATA_W-1:0]  in_b,
    input  logic signed [DATA_W-1:0]  in_c,
    input  logic signed [DATA_W-1:0]  in_d,
    input  logic signed [DATA_W-1:0]  in_e,
    input  logic signed [DATA_W-1:0]  in_f,
    input  logic signed [DATA_W-1:0]  in_g,
    input  logic signed [DATA_W-1:0]  in_h,
    output logic                      mm_start,
    output logic signed [DATA_W-1:0]  mm_a,
    output logic signed [DATA_W-1:0]  mm_b,
    output logic signed [DATA_W-1:0]  mm_c,
    output logic signed [DATA_W-1:0]  mm_d,
    output logic signed [DATA_W-1:0]  mm_e,
    output logic signed [DATA_W-1:0]  mm_f,
    output logic signed [DATA_W-1:0]  mm_g,
    output logic signed [DATA_W-1:0]  mm_h,
    input  logic                      mm_done,
    input  logic signed [PROD_W-1:0]  mm_w,
    input  logic signed [PROD_W-1:0]  mm_x,
    input  logic signed [PROD_W-1:0]  mm_y,
    input  logic signed [PROD_W-1:0]  mm_z,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [PROD_W-1:0]  out_w,
    output logic signed [PROD_W-1:0]  out_x,
    output logic signed [PROD_W-1:0]  out_y,
    output logic signed [PROD_W-1:0]  out_z,
    output logic                      busy,
    output logic                      err
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int WD_W  = $clog2(TIMEOUT+1);
    localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W+1)'(DEPTH);

    mm_operands_t       r_ops;
    logic               r_mm_start;
    logic [CNT_W-1:0]   r_outstanding;
    logic [WD_W-1:0]    r_wdog;
    host_state_t        r_state;

    host_state_t        w_state_nxt;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_outstanding_nxt;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [CNT_W:0]     w_credits;
    logic               w_accept;
    logic               w_done_ok;
    logic               w_spurious;
    logic               w_timeout;
    logic               w_fault;
    logic               w_pop;
    logic               w_out_valid;
    mm_result_t         w_push_data;
    mm_result_t         w_head;

    // Every issued request has a FIFO slot reserved, since the core cannot stall.
    assign w_credits  = {1'b0, r_outstanding} + {1'b0, w_count};
    assign in_ready   = (w_credits < CREDIT_MAX) && (r_state != ST_FAULT);
    assign w_accept   = in_valid && in_ready;
    assign w_done_ok  = mm_done && (r_outstanding != '0);
    assign w_spurious = mm_done && (r_outstanding == '0);
    assign w_timeout  = !mm_done && (r_outstanding != '0) && (r_wdog == WD_W'(TIMEOUT - 1));
    assign w_fault    = w_spurious || w_timeout;
    assign w_pop      = w_out_valid && out_ready;

    always_comb begin
        w_outstanding_nxt = r_outstanding;
        if (w_accept && !w_done_ok) begin
            w_outstanding_nxt = r_outstanding + CNT_W'(1);
        end else if (!w_accept && w_done_ok) begin
            w_outstanding_nxt = r_outstanding - CNT_W'(1);
        end
    end

    always_comb begin
        w_count_nxt = w_count;
        if (w_done_ok && !w_pop) begin
            w_count_nxt = w_count + CNT_W'(1);
        end else if (!w_done_ok && w_pop) begin
            w_count_nxt = w_count - CNT_W'(1);
        end
    end

    // Issue stage: operands registered on accept, start pulses the following cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ops      <= '0;
            r_mm_start <= 1'b0;
        end else begin
            r_mm_start <= w_accept;
            if (w_accept) begin
                r_ops.a <= in_a;
                r_ops.b <= in_b;
                r_ops.c <= in_c;
                r_ops.d <= in_d;
                r_ops.e <= in_e;
                r_ops.f <= in_f;
                r_ops.g <= in_g;
                r_ops.h <= in_h;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_outstanding <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
        end
    end

    // Watchdog saturates so it cannot wrap while a stuck request stays outstanding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdog <= '0;
        end else if (mm_done || (r_outstanding == '0)) begin
            r_wdog <= '0;
        end else if (r_wdog != WD_W'(TIMEOUT)) begin
            r_wdog <= r_wdog + WD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if ((w_outstanding_nxt == '0) && (w_count_nxt == '0)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FAULT: w_state_nxt = ST_FAULT;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (w_fault) begin
            w_state_nxt = ST_FAULT;
        end
    end

    always_comb begin
        w_push_data   = '0;
        w_push_data.w = mm_w;
        w_push_data.x = mm_x;
        w_push_data.y = mm_y;
        w_push_data.z = mm_z;
    end

    // Capture stage: results land in the FIFO the cycle mm_done is seen.
    mat_mult_result_fifo #(
        .DEPTH   (DEPTH)
    ) u_result_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_push  (w_done_ok),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_valid (w_out_valid),
        .o_count (w_count)
    );

    assign mm_start  = r_mm_start;
    assign mm_a      = r_ops.a;
    assign mm_b      = r_ops.b;
    assign mm_c      = r_ops.c;
    assign mm_d      = r_ops.d;
    assign mm_e      = r_ops.e;
    assign mm_f      = r_ops.f;
    assign mm_g      = r_ops.g;
    assign mm_h      = r_ops.h;
    assign out_valid = w_out_valid;
    assign out_w     = w_head.w;
    assign out_x     = w_head.x;
    assign out_y     = w_head.y;
    assign out_z     = w_head.z;
    assign busy      = (r_outstanding != '0) || (w_count != '0);
    assign err       = (r_state == ST_FAULT);

endmodule

// File: tb/tb_mat_mult_2x2_host.sv
// Bench for mat_mult_2x2_host: 3-cycle core model, scoreboard of expected results.
module tb_mat_mult_2x2_host;
    import mat_mult_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [15:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
    logic signed [15:0] in_e = '0, in_f = '0, in_g = '0, in_h = '0;
    logic mm_start;
    logic signed [15:0] mm_a, mm_b, mm_c, mm_d, mm_e, mm_f, mm_g, mm_h;
    logic mm_done;
    logic signed [31:0] mm_w, mm_x, mm_y, mm_z;
    logic out_valid;
    logic out_ready = 1'b0;
    logic signed [31:0] out_w, out_x, out_y, out_z;
    logic busy, err;

    int checks = 0;
    int errors = 0;

    logic       withhold = 1'b0;
    logic       inject = 1'b0;
    mm_result_t inj_r = '0;
    logic [2:0] cm_v;
    mm_result_t cm_r [3];

    mm_result_t sb_q [$];
    mm_result_t sb_exp;
    int n_acc = 0, n_pop = 0, cyc = 0, first_pop = -1, last_pop = -1;

    always #5 clk = ~clk;

    mat_mult_2x2_host #(.DEPTH(8), .TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .in_e(in_e), .in_f(in_f), .in_g(in_g), .in_h(in_h),
        .mm_start(mm_start),
        .mm_a(mm_a), .mm_b(mm_b), .mm_c(mm_c), .mm_d(mm_d),
        .mm_e(mm_e), .mm_f(mm_f), .mm_g(mm_g), .mm_h(mm_h),
        .mm_done(mm_done), .mm_w(mm_w), .mm_x(mm_x), .mm_y(mm_y), .mm_z(mm_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_w(out_w), .out_x(out_x), .out_y(out_y), .out_z(out_z),
        .busy(busy), .err(err)
    );

    function automatic mm_result_t mul(input logic signed [15:0] a, b, c, d, e, f, g, h);
        logic signed [31:0] sa, sb, sc, sd, se, sf, sg, sh;
        mm_result_t r;
        sa = a; sb = b; sc = c; sd = d; se = e; sf = f; sg = g; sh = h;
        r.w = sa * se + sb * sg;
        r.x = sa * sf + sb * sh;
        r.y = sc * se + sd * sg;
        r.z = sc * sf + sd * sh;
        return r;
    endfunction

    task automatic check(input string tag, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Core model: start in cycle k gives done in cycle k+3; reset together with the DUT.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cm_v <= '0;
        end else begin
            cm_v    <= {cm_v[1:0], mm_start};
            cm_r[0] <= mul(mm_a, mm_b, mm_c, mm_d, mm_e, mm_f, mm_g, mm_h);
            cm_r[1] <= cm_r[0];
            cm_r[2] <= cm_r[1];
        end
    end

    assign mm_done = (cm_v[2] && !withhold) || inject;
    assign mm_w = inject ? inj_r.w : cm_r[2].w;
    assign mm_x = inject ? inj_r.x : cm_r[2].x;
    assign mm_y = inject ? inj_r.y : cm_r[2].y;
    assign mm_z = inject ? inj_r.z : cm_r[2].z;

    // Scoreboard: push on input handshake, pop and compare on output handshake.
    always @(negedge clk) begin
        if (reset_n) begin
            cyc++;
            if (in_valid && in_ready) begin
                sb_q.push_back(mul(in_a, in_b, in_c, in_d, in_e, in_f, in_g, in_h));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                n_pop++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_output", 1, 0);
                end else begin
                    sb_exp = sb_q.pop_front();
                    check("sb_out_w", out_w, sb_exp.w);
                    check("sb_out_x", out_x, sb_exp.x);
                    check("sb_out_y", out_y, sb_exp.y);
                    check("sb_out_z", out_z, sb_exp.z);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic signed [15:0] a, b, c, d, e, f, g, h);
        in_a = a; in_b = b; in_c = c; in_d = d;
        in_e = e; in_f = f; in_g = g; in_h = h;
    endtask

    task automatic rand_ops();
        set_ops(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic send1();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_drain(input string tag, input int max);
        int n = 0;
        while (sb_q.size() != 0 && n < max) begin
            tick();
            n++;
        end
        check(tag, sb_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got %0d checks expected completion", checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        int a0, p0, drops, n;

        // Reset values
        #2;
        check("rst_async_in_ready", in_ready, 1);
        check("rst_async_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_mm_start", mm_start, 0);
        check("rst_mm_a", mm_a, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_w", out_w, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);

        // Single op: start at n+1, result visible at n+5
        set_ops(1, 2, 3, 4, 5, 6, 7, 8);
        in_valid = 1'b1;
        check("single_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("single_start_n1", mm_start, 1);
        check("single_mm_a", mm_a, 1);
        check("single_mm_h", mm_h, 8);
        tick();
        check("single_start_n2", mm_start, 0);
        tick();
        tick();
        check("single_out_valid_n4", out_valid, 0);
        tick();
        check("single_out_valid_n5", out_valid, 1);
        check("single_out_w", out_w, 19);
        check("single_out_x", out_x, 22);
        check("single_out_y", out_y, 43);
        check("single_out_z", out_z, 50);
        check("single_busy", busy, 1);
        out_ready = 1'b1;
        tick();
        check("single_busy_after_pop", busy, 0);
        check("single_out_valid_after_pop", out_valid, 0);

        // 20 back-to-back ops with out_ready held high
        p0 = n_pop;
        first_pop = -1;
        drops = 0;
        for (int i = 0; i < 20; i++) begin
            rand_ops();
            in_valid = 1'b1;
            if (!in_ready) drops++;
            tick();
        end
        in_valid = 1'b0;
        wait_drain("b2b_drain", 40);
        check("b2b_ready_drops", drops, 0);
        check("b2b_pops", n_pop - p0, 20);
        check("b2b_span", last_pop - first_pop, 19);

        // Downstream stalled: credits stop accepts at DEPTH
        out_ready = 1'b0;
        a0 = n_acc;
        p0 = n_pop;
        for (int i = 0; i < 15; i++) begin
            rand_ops();
            in_valid = 1'b1;
            tick();
        end
        check("full_accepts", n_acc - a0, 8);
        check("full_in_ready", in_ready, 0);
        check("full_busy", busy, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_ops();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("resume_accepts", (n_acc - a0) > 8, 1);
        wait_drain("resume_drain", 40);
        check("resume_no_loss", n_pop - p0, n_acc - a0);

        // Most-negative operands pass through bit-exact
        out_ready = 1'b0;
        set_ops(-16'sd32768, 16'sd0, 16'($urandom), 16'($urandom),
                -16'sd32768, 16'($urandom), 16'sd0, 16'($urandom));
        send1();
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        check("neg_out_valid", out_valid, 1);
        check("neg_out_w", out_w, 1073741824);
        out_ready = 1'b1;
        wait_drain("neg_drain", 10);

        // Watchdog: withheld mm_done
        withhold = 1'b1;
        rand_ops();
        send1();
        repeat (4) tick();
        check("wd_err_early", err, 0);
        n = 0;
        while (!err && n < 12) begin
            tick();
            n++;
        end
        check("wd_err", err, 1);
        check("wd_in_ready", in_ready, 0);
        a0 = n_acc;
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        check("wd_no_accept", n_acc - a0, 0);
        withhold = 1'b0;
        do_reset();
        check("wd_cleared_by_reset", err, 0);

        // Spurious mm_done while idle
        inj_r = mul(1, 1, 1, 1, 1, 1, 1, 1);
        inject = 1'b1;
        tick();
        inject = 1'b0;
        check("spur_err", err, 1);
        check("spur_in_ready", in_ready, 0);
        tick();
        tick();
        check("spur_fifo_empty", out_valid, 0);
        check("spur_busy", busy, 0);
        do_reset();

        // Asynchronous reset with three ops outstanding
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("mid_busy", busy, 1);
        #2 reset_n = 1'b0;
        sb_q.delete();
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_mm_start", mm_start, 0);
        check("mid_rst_mm_a", mm_a, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_w", out_w, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", err, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (6) tick();
        check("post_rst_err", err, 0);
        p0 = n_pop;
        set_ops(1, 2, 3, 4, 5, 6, 7, 8);
        send1();
        wait_drain("post_rst_drain", 12);
        check("post_rst_pop", n_pop - p0, 1);
        check("post_rst_err_final", err, 0);
        check("post_rst_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
